// File: rtl/result_checker_pkg.sv
// Shared types and helpers for the multi-channel result checker.
// The record layout constants and beat-count helper live here so the top
// level and any later tooling agree on one definition.
package result_checker_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Status word layout: fail flag at bit 0, channel index just above it
  localparam int FAIL_BIT = 0;
  localparam int CH_LSB   = 1;

  // One status beat followed by as many data beats as the vector needs
  function automatic int beat_count(input int vec_w, input int data_w);
    return (vec_w + data_w - 1) / data_w + 1;
  endfunction

endpackage

// File: rtl/multi_channel_result_checker_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer,
// wrapping modulo NUM_CH. Purely combinational; the pointer register lives
// in the parent so it only advances once a record has fully completed.
module rr_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int CH_WIDTH = 3
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_WIDTH-1:0] ptr,
  output logic [NUM_CH-1:0]   grant,
  output logic [CH_WIDTH-1:0] grant_idx,
  output logic                grant_any
);

  // Scan offsets 0..NUM_CH-1 from the pointer; the first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!grant_any && req[c] && (c == ((int'(ptr) + i) % NUM_CH))) begin
          grant_any = 1'b1;
          grant[c]  = 1'b1;
          grant_idx = CH_WIDTH'(c);
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_result_checker.sv
// Multi-channel result checker: compares per-channel result vectors against
// expected vectors under a care mask, arbitrates channels round-robin onto a
// single Avalon-style write master and writes a status word plus the result
// for every vector pair. Keeps saturating pass/fail counters.
// Optional build macro FIRST_FAIL_HALT_EN adds halted/fail_ch/fail_addr and
// stops selecting new pairs after the first failing record until clear_stats.
module multi_channel_result_checker
  import result_checker_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int VEC_WIDTH  = 24,
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        clear_stats,
  output logic                                        idle,
  input  logic [NUM_CH-1:0]                           exp_valid,
  output logic [NUM_CH-1:0]                           exp_ready,
  input  logic [NUM_CH*(2*VEC_WIDTH+ADDR_WIDTH)-1:0]  exp_data,
  input  logic [NUM_CH-1:0]                           res_valid,
  output logic [NUM_CH-1:0]                           res_ready,
  input  logic [NUM_CH*VEC_WIDTH-1:0]                 res_data,
  output logic [ADDR_WIDTH-1:0]                       mem_address,
  output logic [DATA_WIDTH/8-1:0]                     mem_byteenable,
  output logic                                        mem_write,
  output logic [DATA_WIDTH-1:0]                       mem_writedata,
  input  logic                                        mem_waitrequest,
  output logic [CNT_WIDTH-1:0]                        pass_count,
`ifdef FIRST_FAIL_HALT_EN
  output logic                                        halted,
  output logic [CH_WIDTH-1:0]                         fail_ch,
  output logic [ADDR_WIDTH-1:0]                       fail_addr,
`endif
  output logic [CNT_WIDTH-1:0]                        fail_count
);

  localparam int EW     = 2 * VEC_WIDTH + ADDR_WIDTH;
  localparam int NBEAT  = beat_count(VEC_WIDTH, DATA_WIDTH);
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int PAD_W  = (NBEAT - 1) * DATA_WIDTH;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] status_word(input logic fail,
                                                        input logic [CH_WIDTH-1:0] ch);
    logic [DATA_WIDTH-1:0] w;
    w                     = '0;
    w[FAIL_BIT]           = fail;
    w[CH_LSB +: CH_WIDTH] = ch;
    return w;
  endfunction

  function automatic logic [CH_WIDTH-1:0] next_ptr(input logic [CH_WIDTH-1:0] ch);
    if (ch >= CH_WIDTH'(NUM_CH - 1)) return '0;
    return ch + 1'b1;
  endfunction

  state_t                state_q;
  state_t                state_d;
  logic [CH_WIDTH-1:0]   ptr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [CH_WIDTH-1:0]   ch_q;
  logic                  fail_q;
  logic [PAD_W-1:0]      res_sh;
  logic                  halt_q;

  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     grant;
  logic [CH_WIDTH-1:0]   grant_idx;
  logic                  grant_any;
  logic                  take;
  logic                  beat_done;
  logic                  last_beat;
  logic                  rec_done;

  logic [VEC_WIDTH-1:0]  sel_exp;
  logic [VEC_WIDTH-1:0]  sel_mask;
  logic [VEC_WIDTH-1:0]  sel_res;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_fail;

  assign eligible  = exp_valid & res_valid & {NUM_CH{enable & ~halt_q}};
  assign take      = (state_q == ARB) & grant_any & ~reset;
  assign beat_done = mem_write & ~mem_waitrequest;
  assign last_beat = (beat_q == BEAT_W'(NBEAT - 1));
  assign rec_done  = (state_q == WRITE) & beat_done & last_beat;

  assign mem_byteenable = {BYTES{mem_write}};

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Route the granted channel's FIFO heads to the compare logic
  always_comb begin
    sel_exp  = '0;
    sel_mask = '0;
    sel_addr = '0;
    sel_res  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        sel_exp  = exp_data[c*EW +: VEC_WIDTH];
        sel_mask = exp_data[c*EW + VEC_WIDTH +: VEC_WIDTH];
        sel_addr = exp_data[c*EW + 2*VEC_WIDTH +: ADDR_WIDTH];
        sel_res  = res_data[c*VEC_WIDTH +: VEC_WIDTH];
      end
    end
  end

  assign sel_fail = |((sel_res ^ sel_exp) & sel_mask);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  // FSM next state: one selection per record, back to ARB after the last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (take)     state_d = WRITE;
      WRITE:   if (rec_done) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // FSM outputs: FIFO pops only in the selection cycle, idle whenever nothing is in flight
  always_comb begin
    exp_ready = '0;
    res_ready = '0;
    idle      = 1'b0;
    case (state_q)
      ARB: begin
        idle = ~take;
        if (take) begin
          exp_ready = grant;
          res_ready = grant;
        end
      end
      default: idle = 1'b0;
    endcase
  end

  // Write master: registered strobe, address and data held while the slave stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      beat_q        <= '0;
      ptr_q         <= '0;
    end else if (take) begin
      mem_write     <= 1'b1;
      mem_address   <= sel_addr;
      mem_writedata <= status_word(sel_fail, grant_idx);
      beat_q        <= '0;
    end else if ((state_q == WRITE) && beat_done) begin
      if (last_beat) begin
        mem_write <= 1'b0;
        ptr_q     <= next_ptr(ch_q);
      end else begin
        beat_q        <= beat_q + 1'b1;
        mem_address   <= mem_address + ADDR_WIDTH'(BYTES);
        mem_writedata <= res_sh[DATA_WIDTH-1:0];
      end
    end
  end

  // Record payload: result is shifted out least significant slice first
  always_ff @(posedge clock) begin
    if (take) begin
      ch_q   <= grant_idx;
      fail_q <= sel_fail;
      res_sh <= PAD_W'(sel_res);
    end else if ((state_q == WRITE) && beat_done && !last_beat) begin
      res_sh <= res_sh >> DATA_WIDTH;
    end
  end

  // Saturating record counters; a clear in the same cycle as an increment wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (clear_stats) begin
      pass_count <= '0;
      fail_count <= '0;
    end else if (rec_done) begin
      if (fail_q) fail_count <= sat_inc(fail_count);
      else        pass_count <= sat_inc(pass_count);
    end
  end

`ifdef FIRST_FAIL_HALT_EN
  logic [ADDR_WIDTH-1:0] addr_q;

  // Base address of the record in flight, kept for the failure report
  always_ff @(posedge clock) begin
    if (take) addr_q <= sel_addr;
  end

  // Latch the first failing record and stop arbitration until cleared
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted    <= 1'b0;
      fail_ch   <= '0;
      fail_addr <= '0;
    end else if (clear_stats) begin
      halted    <= 1'b0;
      fail_ch   <= '0;
      fail_addr <= '0;
    end else if (rec_done && fail_q && !halted) begin
      halted    <= 1'b1;
      fail_ch   <= ch_q;
      fail_addr <= addr_q;
    end
  end

  assign halt_q = halted;
`else
  assign halt_q = 1'b0;
`endif

endmodule

// File: tb/tb_multi_channel_result_checker.sv
// Directed bench for multi_channel_result_checker with show-ahead FIFO models
// per channel and a write scoreboard filled from an independent record model.
module tb_multi_channel_result_checker;

  localparam int ADDR_WIDTH = 20;
  localparam int DATA_WIDTH = 16;
  localparam int VEC_WIDTH  = 24;
  localparam int NUM_CH     = 2;
  localparam int CH_WIDTH   = 3;
  localparam int CNT_WIDTH  = 16;
  localparam int EW         = 2 * VEC_WIDTH + ADDR_WIDTH;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
  } beat_t;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        enable;
  logic                        clear_stats;
  logic                        idle;
  logic [NUM_CH-1:0]           exp_valid = '0;
  logic [NUM_CH-1:0]           exp_ready;
  logic [NUM_CH*EW-1:0]        exp_data = '0;
  logic [NUM_CH-1:0]           res_valid = '0;
  logic [NUM_CH-1:0]           res_ready;
  logic [NUM_CH*VEC_WIDTH-1:0] res_data = '0;
  logic [ADDR_WIDTH-1:0]       mem_address;
  logic [DATA_WIDTH/8-1:0]     mem_byteenable;
  logic                        mem_write;
  logic [DATA_WIDTH-1:0]       mem_writedata;
  logic                        mem_waitrequest;
  logic [CNT_WIDTH-1:0]        pass_count;
  logic [CNT_WIDTH-1:0]        fail_count;
`ifdef FIRST_FAIL_HALT_EN
  logic                        halted;
  logic [CH_WIDTH-1:0]         fail_ch;
  logic [ADDR_WIDTH-1:0]       fail_addr;
`endif

  int total = 0;
  int bad   = 0;
  int busy_cyc = 0;
  int pop_cnt0 = 0;
  int pop_cnt1 = 0;

  logic [EW-1:0]        eq0[$];
  logic [EW-1:0]        eq1[$];
  logic [VEC_WIDTH-1:0] rq0[$];
  logic [VEC_WIDTH-1:0] rq1[$];
  beat_t                sb[$];
  int                   served[$];

  multi_channel_result_checker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .VEC_WIDTH  (VEC_WIDTH),
    .NUM_CH     (NUM_CH),
    .CH_WIDTH   (CH_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .clear_stats     (clear_stats),
    .idle            (idle),
    .exp_valid       (exp_valid),
    .exp_ready       (exp_ready),
    .exp_data        (exp_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .mem_address     (mem_address),
    .mem_byteenable  (mem_byteenable),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_waitrequest (mem_waitrequest),
    .pass_count      (pass_count),
`ifdef FIRST_FAIL_HALT_EN
    .halted          (halted),
    .fail_ch         (fail_ch),
    .fail_addr       (fail_addr),
`endif
    .fail_count      (fail_count)
  );

  initial forever #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected record for a popped pair, built from the raw FIFO entries
  function automatic void model(input int ch, input logic [EW-1:0] e, input logic [VEC_WIDTH-1:0] r);
    logic [ADDR_WIDTH-1:0] a;
    logic [VEC_WIDTH-1:0]  m;
    logic [VEC_WIDTH-1:0]  x;
    logic [DATA_WIDTH-1:0] st;
    a     = e[EW-1 -: ADDR_WIDTH];
    m     = e[2*VEC_WIDTH-1 -: VEC_WIDTH];
    x     = e[VEC_WIDTH-1:0];
    st    = '0;
    st[0] = |((r ^ x) & m);
    st[3:1] = 3'(ch);
    sb.push_back({a, st});
    sb.push_back({a + 20'd2, r[15:0]});
    sb.push_back({a + 20'd4, 8'h00, r[23:16]});
  endfunction

  // Show-ahead FIFO outputs refreshed shortly after each rising edge
  always @(posedge clock) begin
    #1;
    exp_valid[0] = (eq0.size() != 0);
    exp_valid[1] = (eq1.size() != 0);
    res_valid[0] = (rq0.size() != 0);
    res_valid[1] = (rq1.size() != 0);
    exp_data[EW-1:0]    = (eq0.size() != 0) ? eq0[0] : '0;
    exp_data[2*EW-1:EW] = (eq1.size() != 0) ? eq1[0] : '0;
    res_data[VEC_WIDTH-1:0]           = (rq0.size() != 0) ? rq0[0] : '0;
    res_data[2*VEC_WIDTH-1:VEC_WIDTH] = (rq1.size() != 0) ? rq1[0] : '0;
  end

  // Monitor: pops, scoreboard comparison of completed beats, busy-cycle count
  always @(negedge clock) begin
    if (!idle) busy_cyc++;
    if (exp_ready[0] || res_ready[0]) begin
      check("ready_pair_ch0", 64'(res_ready[0]), 64'(exp_ready[0]));
      check("pop_has_pair_ch0", 64'(eq0.size() != 0 && rq0.size() != 0), 64'd1);
      if (eq0.size() != 0 && rq0.size() != 0) begin
        model(0, eq0.pop_front(), rq0.pop_front());
        served.push_back(0);
        pop_cnt0++;
      end
    end
    if (exp_ready[1] || res_ready[1]) begin
      check("ready_pair_ch1", 64'(res_ready[1]), 64'(exp_ready[1]));
      check("pop_has_pair_ch1", 64'(eq1.size() != 0 && rq1.size() != 0), 64'd1);
      if (eq1.size() != 0 && rq1.size() != 0) begin
        model(1, eq1.pop_front(), rq1.pop_front());
        served.push_back(1);
        pop_cnt1++;
      end
    end
    if (mem_write && !mem_waitrequest) begin
      check("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        beat_t b;
        b = sb.pop_front();
        check("wr_addr", 64'(mem_address), 64'(b.a));
        check("wr_data", 64'(mem_writedata), 64'(b.d));
        check("wr_be", 64'(mem_byteenable), 64'h3);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_pair(input int c, input logic [19:0] a, input logic [23:0] m,
                           input logic [23:0] e, input logic [23:0] r);
    if (c == 0) begin eq0.push_back({a, m, e}); rq0.push_back(r); end
    else        begin eq1.push_back({a, m, e}); rq1.push_back(r); end
  endtask

  task automatic wait_quiet(input string tag, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (n < max && !(idle && sb.size() == 0 &&
                            !(eq0.size() != 0 && rq0.size() != 0) &&
                            !(eq1.size() != 0 && rq1.size() != 0)));
    check({tag, "_done_in_time"}, 64'(n < max), 64'd1);
  endtask

  task automatic wait_beat(input string tag, input logic [19:0] a, input int max);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (n < max && !(mem_write && mem_address == a));
    check({tag, "_beat_seen"}, 64'(n < max), 64'd1);
  endtask

  initial begin
    int ord[4];
    int p0;
    int n;
    ord = '{0, 1, 0, 1};
    reset = 1'b1; enable = 1'b0; clear_stats = 1'b0; mem_waitrequest = 1'b0;
    cyc(3);

    // reset state
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_mem_write", 64'(mem_write), 64'd0);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_writedata", 64'(mem_writedata), 64'd0);
    check("rst_byteenable", 64'(mem_byteenable), 64'd0);
    check("rst_pass", 64'(pass_count), 64'd0);
    check("rst_fail", 64'(fail_count), 64'd0);
    check("rst_exp_ready", 64'(exp_ready), 64'd0);
    reset = 1'b0; enable = 1'b1;

    // single passing pair on channel 0
    push_pair(0, 20'h00100, 24'hFFFFFF, 24'h00A5A5, 24'h00A5A5);
    wait_quiet("t1", 40);
    check("t1_pass", 64'(pass_count), 64'd1);
    check("t1_fail", 64'(fail_count), 64'd0);
    check("t1_pops", 64'(pop_cnt0), 64'd1);

    // masked difference passes, unmasked one fails
    push_pair(1, 20'h00300, 24'hFFFFFE, 24'h123456, 24'h123457);
    wait_quiet("t2a", 40);
    check("t2a_pass", 64'(pass_count), 64'd2);
    push_pair(1, 20'h00310, 24'hFFFFFF, 24'h123456, 24'h123457);
    wait_quiet("t2b", 40);
    check("t2b_fail", 64'(fail_count), 64'd1);
    check("t2b_pass", 64'(pass_count), 64'd2);

    // both channels continuously eligible: strict alternation, full throughput
    served.delete(); busy_cyc = 0;
    push_pair(0, 20'h00400, 24'hFFFFFF, 24'h000001, 24'h000001);
    push_pair(0, 20'h00410, 24'hFFFFFF, 24'hABCDEF, 24'hABCDEF);
    push_pair(1, 20'h00420, 24'hFFFFFF, 24'h777777, 24'h777777);
    push_pair(1, 20'h00430, 24'h0F0000, 24'h000000, 24'h0F0000);
    wait_quiet("t3", 80);
    check("t3_count", 64'(served.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("t3_rr_order", 64'((i < served.size()) ? served[i] : -1), 64'(ord[i]));
    check("t3_busy_cycles", 64'(busy_cyc), 64'd16);
    check("t3_pass", 64'(pass_count), 64'd5);
    check("t3_fail", 64'(fail_count), 64'd2);

    // result without expected on channel 1 is never popped and never blocks channel 0
    served.delete(); p0 = pop_cnt1;
    rq1.push_back(24'h5A5A5A);
    push_pair(0, 20'h00500, 24'hFFFFFF, 24'h0000FF, 24'h0000FF);
    wait_quiet("t4a", 40);
    cyc(4);
    check("t4_served", 64'(served.size()), 64'd1);
    check("t4_ch1_unpopped", 64'(pop_cnt1 - p0), 64'd0);
    check("t4_res_left", 64'(rq1.size()), 64'd1);
    eq1.push_back({20'h00510, 24'hFFFFFF, 24'h5A5A5A});
    wait_quiet("t4b", 40);
    check("t4_res_drained", 64'(rq1.size()), 64'd0);
    check("t4_pass", 64'(pass_count), 64'd7);

    // stall on beat 1 for five cycles
    busy_cyc = 0; p0 = pop_cnt0;
    push_pair(0, 20'h00200, 24'hFFFFFF, 24'h00BEEF, 24'h00BEEF);
    wait_beat("t5", 20'h00200, 20);
    @(posedge clock); #1;
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      check("t5_hold_addr", 64'(mem_address), 64'h00202);
      check("t5_hold_data", 64'(mem_writedata), 64'hBEEF);
      check("t5_hold_write", 64'(mem_write), 64'd1);
      @(posedge clock); #1;
    end
    mem_waitrequest = 1'b0;
    wait_quiet("t5", 40);
    check("t5_busy_cycles", 64'(busy_cyc), 64'd9);
    check("t5_pops", 64'(pop_cnt0 - p0), 64'd1);
    check("t5_pass", 64'(pass_count), 64'd8);

    // enable dropped mid-record: record finishes, nothing new selected
    served.delete();
    push_pair(0, 20'h00A00, 24'hFFFFFF, 24'h010203, 24'h010203);
    push_pair(1, 20'h00A10, 24'hFFFFFF, 24'h040506, 24'h040506);
    n = 0;
    do begin @(negedge clock); #1; n++; end while (n < 20 && served.size() == 0);
    check("t6_selected", 64'(served.size()), 64'd1);
    @(posedge clock); #1;
    enable = 1'b0;
    cyc(10);
    check("t6_one_served", 64'(served.size()), 64'd1);
    check("t6_idle", 64'(idle), 64'd1);
    check("t6_pass", 64'(pass_count), 64'd9);
    enable = 1'b1;
    wait_quiet("t6", 40);
    check("t6_pass_after", 64'(pass_count), 64'd10);

    // fail counter saturates
    force dut.fail_count = 16'hFFFF;
    cyc(1);
    release dut.fail_count;
    push_pair(0, 20'h00600, 24'hFFFFFF, 24'h000000, 24'h000001);
    wait_quiet("t7a", 40);
    check("t7_fail_sat", 64'(fail_count), 64'hFFFF);
    check("t7_pass_kept", 64'(pass_count), 64'd10);

    // clear coincident with a pass completion wins
    push_pair(1, 20'h00610, 24'hFFFFFF, 24'h111111, 24'h111111);
    wait_beat("t7b", 20'h00614, 20);
    clear_stats = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    wait_quiet("t7b", 40);
    check("t7_clear_pass", 64'(pass_count), 64'd0);
    check("t7_clear_fail", 64'(fail_count), 64'd0);

    // record on channel 0 leaves the pointer at 1, then reset mid beat 1 of a channel 1 record
    push_pair(0, 20'h00680, 24'hFFFFFF, 24'h222222, 24'h222222);
    wait_quiet("t8a", 40);
    push_pair(1, 20'h00700, 24'hFFFFFF, 24'h333333, 24'h333333);
    wait_beat("t8", 20'h00702, 20);
    reset = 1'b1;
    #1;
    check("t8_write_drop", 64'(mem_write), 64'd0);
    check("t8_idle_in_reset", 64'(idle), 64'd1);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    check("t8_idle", 64'(idle), 64'd1);
    check("t8_ptr", 64'(dut.ptr_q), 64'd0);
    check("t8_pass", 64'(pass_count), 64'd0);
    check("t8_fail", 64'(fail_count), 64'd0);
    check("t8_addr", 64'(mem_address), 64'd0);
    served.delete();
    push_pair(1, 20'h00720, 24'hFFFFFF, 24'h444444, 24'h444444);
    push_pair(0, 20'h00710, 24'hFFFFFF, 24'h555555, 24'h555555);
    wait_quiet("t8b", 40);
    check("t8_first_ch", 64'((served.size() > 0) ? served[0] : -1), 64'd0);
    check("t8_second_ch", 64'((served.size() > 1) ? served[1] : -1), 64'd1);
    check("t8_pass_after", 64'(pass_count), 64'd2);

`ifdef FIRST_FAIL_HALT_EN
    // first failing record halts selection until clear_stats
    served.delete();
    push_pair(0, 20'h00800, 24'hFFFFFF, 24'h000001, 24'h000002);
    push_pair(1, 20'h00810, 24'hFFFFFF, 24'h666666, 24'h666666);
    n = 0;
    do begin @(negedge clock); #1; n++; end while (n < 40 && !halted);
    check("t9_halted", 64'(halted), 64'd1);
    check("t9_fail_ch", 64'(fail_ch), 64'd0);
    check("t9_fail_addr", 64'(fail_addr), 64'h00800);
    cyc(10);
    check("t9_no_more", 64'(served.size()), 64'd1);
    clear_stats = 1'b1;
    @(posedge clock); #1;
    clear_stats = 1'b0;
    check("t9_unhalted", 64'(halted), 64'd0);
    check("t9_cleared_addr", 64'(fail_addr), 64'd0);
    wait_quiet("t9", 40);
    check("t9_resumed", 64'(served.size()), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_result_checker.md
Name: multi_channel_result_checker

Overview:
Parametrised successor to the single-stream checker. Compares result vectors from NUM_CH target channels against expected vectors under a per-bit care mask. Round-robin arbitrates the channels onto one Avalon-style write master and writes a status-plus-result record per vector. Sits between the per-channel expected/result FIFOs (show-ahead, same clock) and the memory interface write port.

Parameters:
ADDR_WIDTH, 20, memory byte address width
DATA_WIDTH, 16, memory data width; must be a multiple of 8
VEC_WIDTH, 24, result/expected vector width
NUM_CH, 2, number of channels (1..8)
CH_WIDTH, 3, channel index width; must be >= ceil(log2(NUM_CH)) and >= 1
CNT_WIDTH, 16, pass/fail counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; high = accept new vector pairs
clear_stats  in  1  one-cycle pulse; zeroes counters
idle  out  1  no record in flight
exp_valid  in  NUM_CH  expected entry present, per channel
exp_ready  out  NUM_CH  pop expected entry, one-cycle pulse
exp_data  in  NUM_CH*(2*VEC_WIDTH+ADDR_WIDTH)  per channel {addr, mask, expected}, channel 0 at LSBs
res_valid  in  NUM_CH  result entry present
res_ready  out  NUM_CH  pop result entry, one-cycle pulse
res_data  in  NUM_CH*VEC_WIDTH  per channel result, channel 0 at LSBs
mem_address  out  ADDR_WIDTH  write byte address
mem_byteenable  out  DATA_WIDTH/8  always all ones during write
mem_write  out  1  write strobe
mem_writedata  out  DATA_WIDTH  write data
mem_waitrequest  in  1  slave stall
pass_count  out  CNT_WIDTH  records passed, saturating
fail_count  out  CNT_WIDTH  records failed, saturating

Behaviour:
- Reset (async, active-high) clears all outputs to 0 except idle=1. State goes to ARB. Round-robin pointer = 0.
- A channel is eligible when exp_valid[c] & res_valid[c] & enable.
- ARB: choose the first eligible channel at or after the pointer, wrapping modulo NUM_CH. In the same cycle pulse exp_ready[c] and res_ready[c] for exactly one cycle. Capture addr, mask, expected and result. Compute fail = |((res ^ exp) & mask), where mask bit 1 = compare. Go to WRITE. If no channel is eligible, stay in ARB with idle=1.
- WRITE: NBEAT = 1 + ceil(VEC_WIDTH/DATA_WIDTH); default is 3.
  - Beat 0 = status word: bit0 = fail, bits[CH_WIDTH:1] = channel, all other bits zero.
  - Beats 1..NBEAT-1 = result, least significant slice first, zero-extended in the top beat.
  - Beat k address = addr + k*(DATA_WIDTH/8).
  - mem_write is registered. Address and data stay stable while mem_waitrequest=1. A beat completes in the cycle where mem_write=1 and mem_waitrequest=0.
- After the final beat completes:
  - Increment pass_count or fail_count, saturating at all ones.
  - Set pointer = served channel + 1, mod NUM_CH.
  - Return to ARB. The next selection can occur no earlier than the following cycle.
- Throughput with no stalls: one record per NBEAT+1 cycles.
- idle=0 from the selection cycle through the final beat completion.
- enable falling mid-record: the record completes; no new selection.
- clear_stats coinciding with a counter increment: clear wins, counter reads 0.
- exp_valid without res_valid, or the reverse: no pop and no stall of other channels.
- NUM_CH=1: the pointer stays 0.

Optional Feature:
FIRST_FAIL_HALT_EN
- When defined, adds outputs:
  - halted (1)
  - fail_ch (CH_WIDTH)
  - fail_addr (ADDR_WIDTH)
- On completion of the first failing record:
  - Latch that record's channel and address.
  - Assert halted.
  - Select no further pairs until clear_stats, which also clears halted, fail_ch and fail_addr.
- When undefined: the ports are absent and failures never stop the checker.

Decomposition:
- Package result_checker_pkg holds:
  - the state enum (ARB, WRITE)
  - status-word bit positions (FAIL_BIT=0, CH_LSB=1)
  - the beat-count function ceil(VEC_WIDTH/DATA_WIDTH)+1
- One sub-module, rr_arbiter: NUM_CH request vector, pointer in, one-hot grant plus index out. Purely combinational.
- The pointer register stays in the parent.

Test Plan:
- Ch0 pair: exp=0x00A5A5, mask=0xFFFFFF, res=0x00A5A5, addr=0x00100, no waitrequest -> writes 0x0000@0x00100, 0xA5A5@0x00102, 0x0000@0x00104; pass_count=1; exp_ready/res_ready each pulse once.
- Ch1: exp=0x123456, res=0x123457, mask=0xFFFFFE -> pass (masked bit). Same vectors with mask=0xFFFFFF -> status word 0x0003, fail_count=1.
- Both channels continuously eligible for 4 records -> service order 0,1,0,1; a channel with only res_valid set is never popped.
- mem_waitrequest high for 5 cycles on beat 1 -> address/data held constant; total record time 3+1+5 cycles; no extra pops.
- fail_count preloaded to 0xFFFF by forcing, then a failing record -> stays 0xFFFF. clear_stats coincident with a pass completion -> pass_count=0.
- Reset asserted during beat 1 -> mem_write drops immediately; after release idle=1, pointer=0, counters 0. With FIRST_FAIL_HALT_EN: the failing record halts the checker with fail_ch and fail_addr latched; clear_stats resumes it.
